// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and byte-lane helper for the data memory controller.
package dmem_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_READ = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  function automatic logic [3:0] byte_mask(input logic [2:0] memop, input logic [1:0] lo);
    logic [3:0] mask;
    mask = 4'b0000;
    case (memop[1:0])
      2'b00:   mask = 4'b0001 << lo;
      2'b01:   mask = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake bundle between the load/store unit and dmem_ctrl.
interface dmem_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_memop;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_memop, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_memop, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_ram.sv
// DEPTH x 32 storage: byte-enabled write, registered read-first port, combinational debug port.
module dmem_ram #(
  parameter int unsigned DEPTH = 16384
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [31:0]              dbg_rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

  assign dbg_rdata = mem[dbg_addr];

endmodule

// File: rtl/dmem_ctrl.sv
// Single-clock data memory controller: validates requests, writes stores at acceptance and
// returns extended load data one cycle after the synchronous RAM read.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 16384,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  dmem_if.slave                    bus,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [31:0]              dbg_rdata
);

  localparam int unsigned IW = $clog2(DEPTH);

  state_t      state_q, state_d;
  logic [2:0]  memop_q, memop_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [ADDR_W-1:0] addr_hi;
  logic [IW-1:0]     widx;
  logic [1:0]        lo;
  logic              bad_op, st_bad, misalign, fault, accept;
  logic [3:0]        ram_we;
  logic              ram_re;
  logic [31:0]       ram_wdata, ram_rdata, load_data;
  logic [7:0]        sel_b;
  logic [15:0]       sel_h;

  assign addr_hi  = bus.req_addr >> (IW + 2);
  assign widx     = bus.req_addr[IW+1:2];
  assign lo       = bus.req_addr[1:0];
  assign bad_op   = (bus.req_memop == 3'b011) || (bus.req_memop[2:1] == 2'b11);
  assign st_bad   = bus.req_we && bus.req_memop[2];
  assign misalign = ((bus.req_memop[1:0] == 2'b01) && lo[0]) ||
                    ((bus.req_memop[1:0] == 2'b10) && (lo != 2'b00));
  assign fault    = (addr_hi != '0) || bad_op || st_bad || misalign;
  assign accept   = bus.req_valid && (state_q == ST_IDLE);

  assign ram_we = (accept && bus.req_we && !fault) ? byte_mask(bus.req_memop, lo) : 4'b0000;
  assign ram_re = accept && !bus.req_we && !fault;

  always_comb begin
    ram_wdata = bus.req_wdata;
    case (bus.req_memop[1:0])
      2'b00:   ram_wdata = {4{bus.req_wdata[7:0]}};
      2'b01:   ram_wdata = {2{bus.req_wdata[15:0]}};
      default: ram_wdata = bus.req_wdata;
    endcase
  end

  dmem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .we        (ram_we),
    .re        (ram_re),
    .addr      (widx),
    .wdata     (ram_wdata),
    .rdata     (ram_rdata),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  assign sel_b = ram_rdata[{lo_q, 3'b000} +: 8];
  assign sel_h = lo_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

  always_comb begin
    load_data = ram_rdata;
    case (memop_q)
      MEMOP_B:  load_data = {{24{sel_b[7]}}, sel_b};
      MEMOP_H:  load_data = {{16{sel_h[15]}}, sel_h};
      MEMOP_BU: load_data = {24'h0, sel_b};
      MEMOP_HU: load_data = {16'h0, sel_h};
      default:  load_data = ram_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    memop_d = memop_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rdata_d = 32'h0;
          err_d   = fault;
          if (fault || bus.req_we) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_READ;
            memop_d = bus.req_memop;
            lo_d    = lo;
          end
        end
      end
      ST_READ: begin
        rdata_d = load_data;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      memop_q <= 3'b000;
      lo_q    <= 2'b00;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      memop_q <= memop_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl against a byte-array reference model.
module tb_dmem_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned IW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] dbg_addr = '0;
  logic [31:0]   dbg_rdata;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] mbytes [DEPTH*4];

  dmem_if #(.ADDR_W(32)) bus ();

  dmem_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_fault(input logic we, input logic [2:0] memop,
                                     input logic [31:0] addr);
    if (longint'(addr) >= longint'(DEPTH) * 4) return 1'b1;
    if (memop == 3'd3 || memop == 3'd6 || memop == 3'd7) return 1'b1;
    if (we && memop[2]) return 1'b1;
    if (memop[1:0] == 2'd1 && addr[0]) return 1'b1;
    if (memop[1:0] == 2'd2 && addr[1:0] != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] memop, input int unsigned a);
    logic [15:0] h;
    case (memop[1:0])
      2'd0: return memop[2] ? {24'h0, mbytes[a]} : {{24{mbytes[a][7]}}, mbytes[a]};
      2'd1: begin
        h = {mbytes[a+1], mbytes[a]};
        return memop[2] ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: return {mbytes[a+3], mbytes[a+2], mbytes[a+1], mbytes[a]};
    endcase
  endfunction

  function automatic logic [31:0] model_word(input int unsigned w);
    return {mbytes[4*w+3], mbytes[4*w+2], mbytes[4*w+1], mbytes[4*w]};
  endfunction

  task automatic model_store(input logic [2:0] memop, input int unsigned a,
                             input logic [31:0] d);
    int n;
    n = (memop[1:0] == 2'd0) ? 1 : (memop[1:0] == 2'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) mbytes[a+k] = d[8*k +: 8];
  endtask

  task automatic do_req(input logic we, input logic [2:0] memop, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit hold, output logic [31:0] got);
    bit          flt;
    logic [31:0] exp_r, first_r;
    logic        first_e;
    int          lat, n;
    logic [IW-1:0] w;
    flt   = model_fault(we, memop, addr);
    exp_r = (!flt && !we) ? model_load(memop, addr) : 32'h0;
    lat   = (flt || we) ? 1 : 2;
    w     = addr[IW+1:2];
    got   = 32'h0;
    @(negedge clk);
    dbg_addr      = w;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_memop = memop;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = !hold;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("accept_timeout", 32'(n), 32'd0);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    if (we && !flt) model_store(memop, addr, wdata);
    n = 1;
    while (!bus.rsp_valid && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("rdata", bus.rsp_rdata, exp_r);
    check("err", 32'(bus.rsp_err), 32'(flt));
    got     = bus.rsp_rdata;
    first_r = bus.rsp_rdata;
    first_e = bus.rsp_err;
    if (hold) begin
      // A competing store to word 8 must not be taken while the response is stalled.
      dbg_addr      = IW'(8);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_memop = 3'b010;
      bus.req_addr  = 32'h20;
      bus.req_wdata = ~model_word(8);
      for (int c = 0; c < 5; c++) begin
        @(posedge clk);
        #1;
        check("bp_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_rdata", bus.rsp_rdata, first_r);
        check("bp_err", 32'(bus.rsp_err), 32'(first_e));
        check("bp_ready", 32'(bus.req_ready), 32'd0);
        check("bp_noacc", dbg_rdata, model_word(8));
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      dbg_addr      = w;
    end
    @(posedge clk);
    #1;
    check("consumed", 32'(bus.rsp_valid), 32'd0);
    check("dbg_word", dbg_rdata, model_word(w));
  endtask

  logic [31:0] r;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_memop = 3'b000;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 64; i++) do_req(1'b1, 3'b010, 32'(4 * i), $urandom, 1'b0, r);

    do_req(1'b1, 3'b010, 32'h10, 32'h12345678, 1'b0, r);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, r);
    check("lw_lit", r, 32'h12345678);

    do_req(1'b1, 3'b000, 32'h13, 32'h000000AB, 1'b0, r);
    do_req(1'b1, 3'b001, 32'h10, 32'h000080FF, 1'b0, r);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, r);
    check("sub_lw", r, 32'hAB3480FF);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, r);
    check("sub_lb", r, 32'hFFFFFFAB);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, r);
    check("sub_lbu", r, 32'h000000AB);
    do_req(1'b0, 3'b001, 32'h10, 32'h0, 1'b0, r);
    check("sub_lh", r, 32'hFFFF80FF);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, r);
    check("sub_lhu", r, 32'h0000AB34);

    do_req(1'b1, 3'b010, 32'h11, 32'hDEADBEEF, 1'b0, r);
    do_req(1'b0, 3'b001, 32'h21, 32'h0, 1'b0, r);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, 1'b0, r);
    do_req(1'b1, 3'b100, 32'h14, 32'h55555555, 1'b0, r);
    do_req(1'b1, 3'b010, 32'(DEPTH * 4), 32'hCAFEF00D, 1'b0, r);

    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, r);

    do_req(1'b1, 3'b010, 32'h40, 32'h0BADF00D, 1'b0, r);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_memop = 3'b010;
    bus.req_addr  = 32'h80;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rstmid_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstmid_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("rstmid_valid2", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, r);
    check("rstmid_persist", r, 32'h0BADF00D);

    do_req(1'b1, 3'b010, 32'((DEPTH - 1) * 4), 32'hA5C3E1F7, 1'b0, r);
    do_req(1'b0, 3'b010, 32'((DEPTH - 1) * 4), 32'h0, 1'b0, r);
    check("top_word", r, 32'hA5C3E1F7);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) a = a + 32'(DEPTH * 4);
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b0, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
